// File: rtl/regfile_v3_pkg.sv
// Shared types and sizing helpers for the regfile_v3 register file.
// Holds the sweep/ready state encoding and the depth calculation.
package regfile_v3_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEF_DWIDTH = 16;
  localparam int DEF_AWIDTH = 4;

  function automatic int calc_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_v3_if.sv
// Decode-side request bus and registered read responses of regfile_v3.
// master = decode/testbench driver, slave = register file.
interface regfile_v3_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
);

  logic [AWIDTH-1:0] addr_rs;
  logic [AWIDTH-1:0] addr_rt;
  logic [AWIDTH-1:0] addr_rd;
  logic              req_rs;
  logic              req_rt;
  logic              req_rd;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rs;
  logic [DWIDTH-1:0] rt;
  logic              rs_valid;
  logic              rt_valid;
  logic              reg_zero;
  logic              ready;

  modport master (
    output addr_rs, addr_rt, addr_rd, req_rs, req_rt, req_rd, wdata,
    input  rs, rt, rs_valid, rt_valid, reg_zero, ready
  );

  modport slave (
    input  addr_rs, addr_rt, addr_rd, req_rs, req_rt, req_rd, wdata,
    output rs, rt, rs_valid, rt_valid, reg_zero, ready
  );

endinterface

// File: rtl/regfile_v3_clear_seq.sv
// Clear sweep sequencer: steps idx through every entry after clear, then reports ready.
// Latency: ready rises 2**AWIDTH cycles after clear is sampled high, then released.
// Backpressure: none; clear re-sampled high restarts the sweep from entry 0.
module regfile_v3_clear_seq
  import regfile_v3_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              clear,
  output logic              ready,
  output logic              sweep_we,
  output logic [AWIDTH-1:0] sweep_addr
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_we = 1'b0;
    if (state_q == SWEEP) begin
      sweep_we = 1'b1;
      idx_d    = idx_q + AWIDTH'(1);
      if (idx_q == {AWIDTH{1'b1}}) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= SWEEP;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign ready      = (state_q == READY);
  assign sweep_addr = idx_q;

endmodule

// File: rtl/regfile_v3.sv
// 2-read/1-write register file, hardwired-zero r0, clear sweep; REGFILE_BYPASS_EN selects write-first reads.
// Latency: read data and valid appear one cycle after the request edge; writes land on the request edge.
// Backpressure: none; requests are dropped while ready is low (sweep in progress).
module regfile_v3
  import regfile_v3_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic         clk,
  input  logic         clear,
  regfile_v3_if.slave  bus
);

  localparam int DEPTH = calc_depth(AWIDTH);

  logic              ready;
  logic              sweep_we;
  logic [AWIDTH-1:0] sweep_addr;
  logic              port_we;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [DWIDTH-1:0] rs_q, rs_d;
  logic [DWIDTH-1:0] rt_q, rt_d;
  logic              rs_valid_q, rs_valid_d;
  logic              rt_valid_q, rt_valid_d;

  regfile_v3_clear_seq #(
    .AWIDTH (AWIDTH)
  ) u_clear_seq (
    .clk        (clk),
    .clear      (clear),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // Entry 0 is zeroed by the sweep and never written by the port, so it always reads 0.
  assign port_we = ready && bus.req_rd && (bus.addr_rd != '0);

  always_comb begin
    mem_d = mem_q;
    if (!clear) begin
      if (sweep_we) begin
        mem_d[sweep_addr] = '0;
      end else if (port_we) begin
        mem_d[bus.addr_rd] = bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rs_d       = rs_q;
    rt_d       = rt_q;
    rs_valid_d = 1'b0;
    rt_valid_d = 1'b0;
    if (ready && bus.req_rs) begin
      rs_valid_d = 1'b1;
      rs_d       = mem_q[bus.addr_rs];
`ifdef REGFILE_BYPASS_EN
      if (port_we && (bus.addr_rs == bus.addr_rd)) begin
        rs_d = bus.wdata;
      end
`endif
    end
    if (ready && bus.req_rt) begin
      rt_valid_d = 1'b1;
      rt_d       = mem_q[bus.addr_rt];
`ifdef REGFILE_BYPASS_EN
      if (port_we && (bus.addr_rt == bus.addr_rd)) begin
        rt_d = bus.wdata;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rs_q       <= '0;
      rt_q       <= '0;
      rs_valid_q <= 1'b0;
      rt_valid_q <= 1'b0;
    end else begin
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_valid_q <= rs_valid_d;
      rt_valid_q <= rt_valid_d;
    end
  end

  assign bus.rs       = rs_q;
  assign bus.rt       = rt_q;
  assign bus.rs_valid = rs_valid_q;
  assign bus.rt_valid = rt_valid_q;
  assign bus.reg_zero = (rs_q == '0);
  assign bus.ready    = ready;

endmodule

// File: tb/tb_regfile_v3.sv
// Scoreboard bench for regfile_v3: stimulus pushes expected read data, a negedge monitor pops on valid.
// Build with +define+REGFILE_BYPASS_EN to check the write-first variant.
module tb_regfile_v3;

  logic clk = 1'b0;
  logic clear;

  regfile_v3_if #(.DWIDTH(16), .AWIDTH(4)) bus ();

  regfile_v3 #(
    .DWIDTH (16),
    .AWIDTH (4)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] q_rs[$];
  logic [15:0] q_rt[$];

`ifdef REGFILE_BYPASS_EN
  localparam logic [15:0] SAME_EDGE_EXP = 16'h0008;
`else
  localparam logic [15:0] SAME_EDGE_EXP = 16'h0002;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per valid pulse; a valid with nothing queued is itself an error.
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.rs_valid === 1'b1) begin
      checks++;
      if (q_rs.size() == 0) begin
        errors++;
        $display("FAIL rs_unexpected_valid: got rs=%0h with no request outstanding", bus.rs);
      end else begin
        e = q_rs.pop_front();
        if (bus.rs !== e || bus.reg_zero !== (e == 16'h0)) begin
          errors++;
          $display("FAIL rs_data: got rs=%0h reg_zero=%0b expected rs=%0h reg_zero=%0b",
                   bus.rs, bus.reg_zero, e, (e == 16'h0));
        end
      end
    end
    if (bus.rt_valid === 1'b1) begin
      checks++;
      if (q_rt.size() == 0) begin
        errors++;
        $display("FAIL rt_unexpected_valid: got rt=%0h with no request outstanding", bus.rt);
      end else begin
        e = q_rt.pop_front();
        if (bus.rt !== e) begin
          errors++;
          $display("FAIL rt_data: got rt=%0h expected rt=%0h", bus.rt, e);
        end
      end
    end
  end

  // One cycle of requests; expected data is queued only when the block should answer.
  task automatic op(input logic wen, input logic [3:0] wa, input logic [15:0] wd,
                    input logic rsr, input logic [3:0] as, input logic [15:0] exp_s,
                    input logic rtr, input logic [3:0] at, input logic [15:0] exp_t,
                    input logic answer);
    bus.req_rd  = wen;
    bus.addr_rd = wa;
    bus.wdata   = wd;
    bus.req_rs  = rsr;
    bus.addr_rs = as;
    bus.req_rt  = rtr;
    bus.addr_rt = at;
    if (answer && rsr) q_rs.push_back(exp_s);
    if (answer && rtr) q_rt.push_back(exp_t);
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    bus.req_rs = 1'b0;
    bus.req_rt = 1'b0;
  endtask

  task automatic idle();
    op(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk(name, n, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear       = 1'b1;
    bus.req_rs  = 1'b0;
    bus.req_rt  = 1'b0;
    bus.req_rd  = 1'b0;
    bus.addr_rs = '0;
    bus.addr_rt = '0;
    bus.addr_rd = '0;
    bus.wdata   = '0;

    @(posedge clk);
    #1;
    chk("reset_rs", bus.rs, 0);
    chk("reset_rt", bus.rt, 0);
    chk("reset_rs_valid", bus.rs_valid, 0);
    chk("reset_rt_valid", bus.rt_valid, 0);
    chk("reset_ready", bus.ready, 0);
    chk("reset_reg_zero", bus.reg_zero, 1);
    @(posedge clk);
    #1;
    chk("hold_clear_ready", bus.ready, 0);
    clear = 1'b0;

    // 1: sweep length, then reads of fresh entries return zero
    wait_ready("sweep_cycles");
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h0, 1'b1, 4'd9, 16'h0, 1'b1);
    idle();

    // 2: plain writes then reads on both ports
    op(1'b1, 4'd1, 16'h0001, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    op(1'b1, 4'd2, 16'h0002, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 16'h0001, 1'b1, 4'd2, 16'h0002, 1'b1);
    idle();

    // 3: r0 ignores writes, including a same-edge read of r0
    op(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    op(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h0, 1'b1);
    idle();

    // 4: same-edge write and read of the same address
    op(1'b1, 4'd2, 16'h0008, 1'b1, 4'd2, SAME_EDGE_EXP, 1'b0, 4'd0, 16'h0, 1'b1);
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 16'h0008, 1'b0, 4'd0, 16'h0, 1'b1);
    idle();

    // 5: same-edge write and read of different addresses, then dual read of one address
    op(1'b1, 4'd3, 16'h0008, 1'b1, 4'd2, 16'h0008, 1'b1, 4'd1, 16'h0001, 1'b1);
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h0008, 1'b1, 4'd3, 16'h0008, 1'b1);
    idle();
    chk("hold_rs", bus.rs, 16'h0008);
    chk("hold_rs_valid", bus.rs_valid, 0);
    chk("hold_rt", bus.rt, 16'h0008);

    // 6: clear mid-sweep; requests during the sweep must be ignored
    op(1'b1, 4'd4, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    op(1'b1, 4'd5, 16'h0055, 1'b1, 4'd4, 16'h0, 1'b1, 4'd3, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      op(1'b1, 4'd6, 16'h0066, 1'b1, 4'd1, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
    end
    chk("mid_sweep_ready", bus.ready, 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("reclear_ready", bus.ready, 0);
    chk("reclear_rs", bus.rs, 0);
    chk("reclear_reg_zero", bus.reg_zero, 1);
    clear = 1'b0;
    wait_ready("resweep_cycles");
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 16'h0, 1'b1, 4'd3, 16'h0, 1'b1);
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h0, 1'b1, 4'd6, 16'h0, 1'b1);
    op(1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 16'h0, 1'b1, 4'd2, 16'h0, 1'b1);
    idle();
    idle();

    chk("rs_queue_drained", q_rs.size(), 0);
    chk("rt_queue_drained", q_rt.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
